// File: rtl/main_control_fsm.sv
// main_control_fsm
//   Multicycle MIPS main control unit. Moore FSM that steps through
//   FETCH/DECODE/execute/writeback for each instruction and decodes the IR
//   opcode into datapath strobes. ula_operation feeds ula_control.
//
// Ports
//   clock          in   rising-edge system clock
//   reset          in   asynchronous, active-high
//   opcode[5:0]    in   IR[31:26], stable from DECODE until the next FETCH
//   mem_ready      in   memory access for this cycle completes
//   pc_write       out  unconditional PC load
//   pc_write_cond  out  PC load when the branch condition holds
//   branch_ne      out  selects bne sense of the branch condition
//   i_or_d         out  memory address: 0 PC, 1 ula_out
//   mem_read       out  memory read strobe
//   mem_write      out  memory write strobe
//   ir_write       out  IR load
//   reg_write      out  register file write enable
//   reg_dst[1:0]   out  00 rt, 01 rd, 10 $31
//   mem_to_reg[1:0] out 00 ula_out, 01 MDR, 10 PC
//   ula_src_a      out  0 PC, 1 reg A
//   ula_src_b[1:0] out  00 reg B, 01 const 4, 10 ext imm, 11 sign-ext imm<<2
//   ext_zero       out  immediate zero-extended (andi/ori/xori)
//   ula_operation[3:0] out operation code for ula_control
//   illegal        out  unsupported opcode flag
//   pc_source[1:0] out  PC mux: 00 ula result, 01 ula_out (branch), 10 jump target
//   state[3:0]     out  current state (debug)
//
// State table
//   IDLE      (0)  | one cycle after reset, all outputs low
//   FETCH     (1)  | read instruction at PC, PC+4; waits for mem_ready
//   DECODE    (2)  | compute branch target, dispatch on opcode
//   MEM_ADDR  (3)  | effective address for lw/sw
//   MEM_READ  (4)  | data read, waits for mem_ready
//   MEM_WB    (5)  | lw writeback from MDR
//   MEM_WRITE (6)  | data write, waits for mem_ready
//   R_EXEC    (7)  | R-type ALU operation
//   R_WB      (8)  | R-type writeback to rd
//   BRANCH    (9)  | beq/bne compare and conditional PC load
//   JUMP      (10) | j/jal PC load, jal links into $31
//   I_EXEC    (11) | immediate ALU operation
//   I_WB      (12) | immediate writeback to rt
//   TRAP      (13) | illegal opcode
module main_control_fsm #(
  parameter bit MEM_WAIT_EN  = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       ula_src_a,
  output logic [1:0] ula_src_b,
  output logic       ext_zero,
  output logic [3:0] ula_operation,
  output logic       illegal,
  output logic [1:0] pc_source,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    R_EXEC    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    I_EXEC    = 4'd11,
    I_WB      = 4'd12,
    TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  state_t cur, nxt;
  logic   mem_go;

  // Immediate-group ALU code from funct bits opcode[2:0] of 001xxx.
  function automatic logic [3:0] i_alu_op(input logic [2:0] f);
    case (f)
      3'd2:    i_alu_op = 4'b0011;  // slti
      3'd3:    i_alu_op = 4'b1000;  // sltiu
      3'd4:    i_alu_op = 4'b0100;  // andi
      3'd5:    i_alu_op = 4'b0101;  // ori
      3'd6:    i_alu_op = 4'b0110;  // xori
      3'd7:    i_alu_op = 4'b0111;  // lui
      default: i_alu_op = 4'b0000;  // addi, addiu
    endcase
  endfunction

  // Logical immediates are zero-extended; arithmetic and lui sign-extend.
  function automatic logic i_zero_ext(input logic [2:0] f);
    i_zero_ext = (f == 3'd4) || (f == 3'd5) || (f == 3'd6);
  endfunction

  assign mem_go = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state  = cur;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt           = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    ula_src_a     = 1'b0;
    ula_src_b     = 2'b00;
    ext_zero      = 1'b0;
    ula_operation = 4'b0000;
    illegal       = 1'b0;
    pc_source     = 2'b00;

    case (cur)
      IDLE: nxt = FETCH;

      FETCH: begin
        mem_read  = 1'b1;
        ula_src_b = 2'b01;
        // IR and PC load only on the cycle the instruction word arrives.
        if (mem_go) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = DECODE;
        end else begin
          nxt = FETCH;
        end
      end

      DECODE: begin
        ula_src_b = 2'b11;
        case (opcode)
          OP_R:          nxt = R_EXEC;
          OP_LW, OP_SW:  nxt = MEM_ADDR;
          OP_BEQ, OP_BNE: nxt = BRANCH;
          OP_J, OP_JAL:  nxt = JUMP;
          default:       nxt = (opcode[5:3] == 3'b001) ? I_EXEC : TRAP;
        endcase
      end

      MEM_ADDR: begin
        ula_src_a = 1'b1;
        ula_src_b = 2'b10;
        nxt       = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end

      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        nxt      = mem_go ? MEM_WB : MEM_READ;
      end

      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        nxt        = FETCH;
      end

      MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        nxt       = mem_go ? FETCH : MEM_WRITE;
      end

      R_EXEC: begin
        ula_src_a     = 1'b1;
        ula_operation = 4'b0010;
        nxt           = R_WB;
      end

      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        nxt       = FETCH;
      end

      BRANCH: begin
        ula_src_a     = 1'b1;
        ula_operation = 4'b0001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OP_BNE);
        nxt           = FETCH;
      end

      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        nxt = FETCH;
      end

      I_EXEC: begin
        ula_src_a     = 1'b1;
        ula_src_b     = 2'b10;
        ula_operation = i_alu_op(opcode[2:0]);
        ext_zero      = i_zero_ext(opcode[2:0]);
        nxt           = I_WB;
      end

      // ALU code and extension mode held so the result stays stable at writeback.
      I_WB: begin
        reg_write     = 1'b1;
        ula_operation = i_alu_op(opcode[2:0]);
        ext_zero      = i_zero_ext(opcode[2:0]);
        nxt           = FETCH;
      end

      TRAP: begin
        illegal = 1'b1;
        nxt     = ILLEGAL_TRAP ? TRAP : FETCH;
      end

      default: nxt = FETCH;
    endcase
  end

endmodule

// File: tb/tb_main_control_fsm.sv
module tb_main_control_fsm;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic       ext_zero;
    logic [3:0] ula_operation;
    logic       illegal;
    logic [1:0] pc_source;
  } outs_t;

  typedef struct {
    logic [5:0] opc;
    logic       rdy;
    logic [3:0] st;
    outs_t      o;
  } cyc_t;

  typedef struct {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;

  logic       pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic       ir_write, reg_write, ula_src_a, ext_zero, illegal;
  logic [1:0] reg_dst, mem_to_reg, ula_src_b, pc_source;
  logic [3:0] ula_operation, state;

  logic       pc_write_t, pc_write_cond_t, branch_ne_t, i_or_d_t, mem_read_t, mem_write_t;
  logic       ir_write_t, reg_write_t, ula_src_a_t, ext_zero_t, illegal_t;
  logic [1:0] reg_dst_t, mem_to_reg_t, ula_src_b_t, pc_source_t;
  logic [3:0] ula_operation_t, state_t;

  outs_t act, act_t;

  cyc_t plan[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  always #5 clock = ~clock;

  main_control_fsm u_dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .ula_src_a(ula_src_a), .ula_src_b(ula_src_b), .ext_zero(ext_zero),
    .ula_operation(ula_operation), .illegal(illegal), .pc_source(pc_source),
    .state(state)
  );

  main_control_fsm #(.ILLEGAL_TRAP(1'b1)) u_trap (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_t), .pc_write_cond(pc_write_cond_t), .branch_ne(branch_ne_t),
    .i_or_d(i_or_d_t), .mem_read(mem_read_t), .mem_write(mem_write_t), .ir_write(ir_write_t),
    .reg_write(reg_write_t), .reg_dst(reg_dst_t), .mem_to_reg(mem_to_reg_t),
    .ula_src_a(ula_src_a_t), .ula_src_b(ula_src_b_t), .ext_zero(ext_zero_t),
    .ula_operation(ula_operation_t), .illegal(illegal_t), .pc_source(pc_source_t),
    .state(state_t)
  );

  assign act = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, ula_src_a, ula_src_b, ext_zero,
                ula_operation, illegal, pc_source};
  assign act_t = {pc_write_t, pc_write_cond_t, branch_ne_t, i_or_d_t, mem_read_t, mem_write_t,
                  ir_write_t, reg_write_t, reg_dst_t, mem_to_reg_t, ula_src_a_t, ula_src_b_t,
                  ext_zero_t, ula_operation_t, illegal_t, pc_source_t};

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, a, r);
    end
  endtask

  // Monitor: one expected cycle per falling edge while the scoreboard holds entries.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cyc_no++;
      check($sformatf("state@%0d", cyc_no), 32'(state), 32'(e.st));
      check($sformatf("outs@%0d", cyc_no), 32'(act), 32'(e.o));
    end
  end

  // Reference: instruction-level schedule of which step runs each cycle and
  // which strobes that step raises.
  function automatic logic [3:0] i_alu(input logic [5:0] op);
    logic [3:0] tab [8];
    tab = '{4'b0000, 4'b0000, 4'b0011, 4'b1000, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
    return tab[op[2:0]];
  endfunction

  task automatic add(input logic [5:0] opc, input logic rdy, input logic [3:0] st, input outs_t o);
    cyc_t c;
    c.opc = opc; c.rdy = rdy; c.st = st; c.o = o;
    plan.push_back(c);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic gen_instr(input logic [5:0] op, input int wf, input int wm);
    outs_t o;
    for (int i = 0; i < wf; i++) begin
      o = '0; o.mem_read = 1'b1; o.ula_src_b = 2'b01;
      add(6'($urandom), 1'b0, 4'd1, o);
    end
    o = '0; o.mem_read = 1'b1; o.ula_src_b = 2'b01; o.ir_write = 1'b1; o.pc_write = 1'b1;
    add(6'($urandom), 1'b1, 4'd1, o);
    o = '0; o.ula_src_b = 2'b11;
    add(op, rb(), 4'd2, o);
    if (op == 6'b000000) begin
      o = '0; o.ula_src_a = 1'b1; o.ula_operation = 4'b0010;
      add(op, rb(), 4'd7, o);
      o = '0; o.reg_write = 1'b1; o.reg_dst = 2'b01;
      add(op, rb(), 4'd8, o);
    end else if (op == 6'b100011 || op == 6'b101011) begin
      logic       is_sw;
      logic [3:0] mst;
      is_sw = (op == 6'b101011);
      mst   = is_sw ? 4'd6 : 4'd4;
      o = '0; o.ula_src_a = 1'b1; o.ula_src_b = 2'b10;
      add(op, rb(), 4'd3, o);
      o = '0; o.i_or_d = 1'b1;
      if (is_sw) o.mem_write = 1'b1; else o.mem_read = 1'b1;
      for (int i = 0; i < wm; i++) add(op, 1'b0, mst, o);
      add(op, 1'b1, mst, o);
      if (!is_sw) begin
        o = '0; o.reg_write = 1'b1; o.mem_to_reg = 2'b01;
        add(op, rb(), 4'd5, o);
      end
    end else if (op == 6'b000100 || op == 6'b000101) begin
      o = '0; o.ula_src_a = 1'b1; o.ula_operation = 4'b0001; o.pc_write_cond = 1'b1;
      o.pc_source = 2'b01; o.branch_ne = (op == 6'b000101);
      add(op, rb(), 4'd9, o);
    end else if (op == 6'b000010 || op == 6'b000011) begin
      o = '0; o.pc_write = 1'b1; o.pc_source = 2'b10;
      if (op == 6'b000011) begin
        o.reg_write = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10;
      end
      add(op, rb(), 4'd10, o);
    end else if (op[5:3] == 3'b001) begin
      logic ez;
      ez = (op[2:0] >= 3'd4) && (op[2:0] <= 3'd6);
      o = '0; o.ula_src_a = 1'b1; o.ula_src_b = 2'b10; o.ula_operation = i_alu(op); o.ext_zero = ez;
      add(op, rb(), 4'd11, o);
      o = '0; o.reg_write = 1'b1; o.ula_operation = i_alu(op); o.ext_zero = ez;
      add(op, rb(), 4'd12, o);
    end else begin
      o = '0; o.illegal = 1'b1;
      add(op, rb(), 4'd13, o);
    end
  endtask

  // Stimulus: drive each planned cycle after the rising edge and post its expectation.
  task automatic run_plan(input int n);
    int lim;
    lim = (n < 0 || n > plan.size()) ? plan.size() : n;
    for (int i = 0; i < lim; i++) begin
      exp_t e;
      @(posedge clock); #1;
      opcode    = plan[i].opc;
      mem_ready = plan[i].rdy;
      e.st = plan[i].st;
      e.o  = plan[i].o;
      sb.push_back(e);
    end
    plan.delete();
  endtask

  task automatic drain();
    @(negedge clock); #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic post_idle();
    exp_t e;
    e.st = 4'd0;
    e.o  = '0;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pool [15];
    logic [5:0] op;
    pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011,
             6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100, 6'b001101, 6'b001110,
             6'b001111};

    @(negedge clock); #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outs", 32'(act), 32'd0);

    @(posedge clock); #1;
    reset = 1'b0;
    opcode = 6'($urandom); mem_ready = rb();
    post_idle();

    // Directed: R, lw with 3 stall cycles, bne, ori, jal, then the remaining
    // classes, with the illegal opcode last.
    gen_instr(6'b000000, 0, 0);
    gen_instr(6'b100011, 0, 3);
    gen_instr(6'b000101, 0, 0);
    gen_instr(6'b001101, 0, 0);
    gen_instr(6'b000011, 0, 0);
    gen_instr(6'b101011, 1, 2);
    gen_instr(6'b000100, 2, 0);
    gen_instr(6'b000010, 0, 0);
    gen_instr(6'b001000, 0, 0);
    gen_instr(6'b001010, 0, 0);
    gen_instr(6'b001011, 0, 0);
    gen_instr(6'b001100, 0, 0);
    gen_instr(6'b001110, 0, 0);
    gen_instr(6'b001111, 0, 0);
    gen_instr(6'b111111, 0, 0);
    run_plan(-1);
    drain();
    check("trap_inst_state", 32'(state_t), 32'd13);
    check("trap_inst_illegal", 32'(illegal_t), 32'd1);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 5) == 0) op = 6'($urandom);
      else op = pool[$urandom_range(0, 14)];
      gen_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    run_plan(-1);
    drain();
    check("trap_inst_stuck", 32'(state_t), 32'd13);

    // Reset while sw waits in MEM_WRITE: strobes drop before the next edge.
    gen_instr(6'b101011, 0, 5);
    run_plan(4);
    @(negedge clock); #1;
    reset = 1'b1;
    #1;
    check("midreset_mem_write", 32'(mem_write), 32'd0);
    check("midreset_state", 32'(state), 32'd0);
    check("midreset_outs", 32'(act), 32'd0);
    check("midreset_trap_state", 32'(state_t), 32'd0);
    check("midreset_trap_outs", 32'(act_t), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    post_idle();
    gen_instr(6'b000000, 0, 0);
    run_plan(-1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
